// File: rtl/mem_pkg.sv
// Shared definitions for the CPU memory responder: FSM encoding, memory map
// defaults and the address region decode.
package mem_pkg;

  localparam int MEM_AW = 13;
  localparam int ROM_AW = 10;
  localparam int RAM_AW = 8;
  localparam logic [MEM_AW-1:0] RAM_BASE = 13'h1800;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_ERRW  = 2'd3;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_ROM  = 2'd1,
    REG_RAM  = 2'd2
  } region_t;

  // ROM sits at the bottom of the map; RAM is one aligned 2^ram_aw block at base.
  function automatic region_t region_of(input logic [MEM_AW-1:0] a,
                                        input logic [MEM_AW-1:0] base,
                                        input int rom_aw,
                                        input int ram_aw);
    if ((a >> rom_aw) == '0) return REG_ROM;
    if ((a >> ram_aw) == (base >> ram_aw)) return REG_RAM;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/sp_mem.sv
// Generic single-port synchronous array with a registered read port.
// Contents are never reset.
module sp_mem #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[a] <= d;
    q <= mem[a];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 8-bit CPU bus: ROM + RAM behind rd/wr strobes,
// with a sticky error flag and a ROM preload port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int ROM_AW = mem_pkg::ROM_AW,
  parameter int RAM_AW = mem_pkg::RAM_AW,
  parameter logic [AW-1:0] RAM_BASE = mem_pkg::RAM_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     data_in,
  output logic [DW-1:0]     data_out,
  output logic              data_oe,
  output logic              err,
  input  logic              prog_we,
  input  logic [ROM_AW-1:0] prog_addr,
  input  logic [DW-1:0]     prog_data
);

  logic [1:0]        state, state_nx;
  region_t           cur_region, rd_region;
  logic              set_err, ram_wr_req;
  logic              ram_we, rom_we;
  logic [ROM_AW-1:0] rom_a;
  logic [DW-1:0]     rom_q, ram_q;

  assign cur_region = region_of(addr, RAM_BASE, ROM_AW, RAM_AW);

  always_comb begin
    state_nx   = state;
    set_err    = 1'b0;
    ram_wr_req = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd && wr) begin
          state_nx = ST_ERRW;
          set_err  = 1'b1;
        end else if (rd) begin
          state_nx = ST_READ;
          set_err  = (cur_region == REG_NONE);
        end else if (wr) begin
          state_nx = ST_WRITE;
          if (cur_region == REG_RAM) ram_wr_req = 1'b1;
          else                       set_err    = 1'b1;
        end
      end
      ST_READ: begin
        if (wr) begin
          state_nx = ST_ERRW;
          set_err  = 1'b1;
        end else if (!rd) begin
          state_nx = ST_IDLE;
        end else begin
          set_err = (cur_region == REG_NONE);
        end
      end
      ST_WRITE: if (!wr) state_nx = ST_IDLE;
      default:  if (!rd && !wr) state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      err       <= 1'b0;
      rd_region <= REG_NONE;
    end else begin
      state     <= state_nx;
      rd_region <= cur_region;
      if (set_err) err <= 1'b1;
    end
  end

  // Reset wins over a same-edge store; preload only on an idle bus.
  assign ram_we = ram_wr_req && !rst;
  assign rom_we = prog_we && (state == ST_IDLE) && !rd && !wr && !rst;
  assign rom_a  = rom_we ? prog_addr : addr[ROM_AW-1:0];

  sp_mem #(.DEPTH(2**ROM_AW), .WIDTH(DW)) u_rom (
    .clk (clk),
    .we  (rom_we),
    .a   (rom_a),
    .d   (prog_data),
    .q   (rom_q)
  );

  sp_mem #(.DEPTH(2**RAM_AW), .WIDTH(DW)) u_ram (
    .clk (clk),
    .we  (ram_we),
    .a   (addr[RAM_AW-1:0]),
    .d   (data_in),
    .q   (ram_q)
  );

  assign data_oe = (state == ST_READ);

  always_comb begin
    data_out = '0;
    if (state == ST_READ) begin
      case (rd_region)
        REG_ROM: data_out = rom_q;
        REG_RAM: data_out = ram_q;
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst, rd, wr, prog_we, err, data_oe;
  logic [12:0] addr;
  logic [7:0]  data_in, data_out, prog_data;
  logic [9:0]  prog_addr;

  int total = 0;
  int bad   = 0;

  mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .err       (err),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick(); tick();
    rst = 1'b0;

    // preload ROM
    prog_we = 1'b1; prog_addr = 10'h005; prog_data = 8'hA7; tick();
    prog_addr = 10'h006; prog_data = 8'h5B; tick();
    prog_we = 1'b0;

    // seed RAM[0x1800]
    wr = 1'b1; addr = 13'h1800; data_in = 8'h11; tick();
    wr = 1'b0; tick();

    // reset with both strobes high
    rst = 1'b1; rd = 1'b1; wr = 1'b1; data_in = 8'h55; tick(); tick();
    chk("rst_oe", 8'(data_oe), 8'h00);
    chk("rst_out", data_out, 8'h00);
    chk("rst_err", 8'(err), 8'h00);
    rst = 1'b0; rd = 1'b0; wr = 1'b0; tick();

    rd = 1'b1; addr = 13'h1800; tick();
    chk("rst_nowrite_oe", 8'(data_oe), 8'h01);
    chk("rst_nowrite_ram", data_out, 8'h11);
    rd = 1'b0; tick();

    // ROM read, address tracking, release
    rd = 1'b1; addr = 13'h0005; tick();
    chk("rom_rd_c1_oe", 8'(data_oe), 8'h01);
    chk("rom_rd_c1", data_out, 8'hA7);
    tick();
    chk("rom_rd_c2", data_out, 8'hA7);
    addr = 13'h0006; tick();
    chk("rom_rd_track", data_out, 8'h5B);
    rd = 1'b0; tick();
    chk("rom_rd_end_oe", 8'(data_oe), 8'h00);
    chk("rom_rd_end_out", data_out, 8'h00);
    chk("rom_rd_err", 8'(err), 8'h00);

    // RAM single write and readback
    wr = 1'b1; addr = 13'h1842; data_in = 8'h3C; tick();
    wr = 1'b0; tick();
    rd = 1'b1; tick();
    chk("ram_rdback", data_out, 8'h3C);
    rd = 1'b0; tick();

    // held wr commits once
    wr = 1'b1; data_in = 8'h3C; tick();
    data_in = 8'hFF; tick(); tick();
    wr = 1'b0; tick();
    rd = 1'b1; tick();
    chk("ram_one_commit", data_out, 8'h3C);
    rd = 1'b0; tick();
    chk("ram_wr_err", 8'(err), 8'h00);

    // ROM write protect
    wr = 1'b1; addr = 13'h0005; data_in = 8'h00; tick();
    chk("rom_wp_err", 8'(err), 8'h01);
    wr = 1'b0; tick();
    rd = 1'b1; tick();
    chk("rom_wp_data", data_out, 8'hA7);
    rd = 1'b0; tick(); tick();
    chk("err_sticky", 8'(err), 8'h01);

    // unmapped read
    rst = 1'b1; tick(); rst = 1'b0;
    chk("err_cleared", 8'(err), 8'h00);
    rd = 1'b1; addr = 13'h0800; tick();
    chk("unmap_out", data_out, 8'h00);
    chk("unmap_err", 8'(err), 8'h01);
    rd = 1'b0; tick();

    // rd+wr conflict
    rst = 1'b1; tick(); rst = 1'b0;
    rd = 1'b1; wr = 1'b1; addr = 13'h1800; data_in = 8'h99; tick();
    chk("conf_err", 8'(err), 8'h01);
    chk("conf_oe", 8'(data_oe), 8'h00);
    wr = 1'b0; tick();
    chk("errw_hold_oe", 8'(data_oe), 8'h00);
    rd = 1'b0; tick();
    rd = 1'b1; tick();
    chk("conf_ram", data_out, 8'h11);
    rd = 1'b0; tick();

    // wr during read
    rst = 1'b1; tick(); rst = 1'b0;
    rd = 1'b1; addr = 13'h1842; tick();
    wr = 1'b1; tick();
    chk("rdwr_err", 8'(err), 8'h01);
    chk("rdwr_oe", 8'(data_oe), 8'h00);
    rd = 1'b0; wr = 1'b0; tick();

    // mid-read reset, preload during read ignored
    rd = 1'b1; addr = 13'h0005; tick();
    prog_we = 1'b1; prog_addr = 10'h005; prog_data = 8'hEE; tick();
    rst = 1'b1; tick();
    chk("midrst_oe", 8'(data_oe), 8'h00);
    chk("midrst_out", data_out, 8'h00);
    rst = 1'b0; rd = 1'b0; prog_we = 1'b0; tick();
    rd = 1'b1; tick();
    chk("prog_ignored", data_out, 8'hA7);
    rd = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
